pipe_ctrl: RTL

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It takes decode-stage register indices, EX-stage control (memRD, doBranch, doJump, branch outcome) and the data-memory handshake, and drives per-stage write-enables, flushes and the PC redirect select. It also owns a memory-wait timeout with a sticky error halt and two saturating performance counters.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/sequencing controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERROR   = 2'd2
   } pipe_state_t;

   localparam logic [4:0] REG_X0     = 5'd0;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // True when an ID operand is actually read and names the EX destination.
   function automatic logic src_matches(input logic       uses,
                                        input logic [4:0] src,
                                        input logic [4:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   // NOTE: reset is synchronous, so rstN is tested inside the clocked block only.
   always_ff @(posedge clk) begin
      if (!rstN) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller: stalls, flushes, PC redirect, memory-wait
// timeout with sticky error halt, and saturating stall/flush counters.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [4:0]       idRs1,
   input  logic [4:0]       idRs2,
   input  logic             idUsesRs1,
   input  logic             idUsesRs2,
   input  logic [4:0]       exRd,
   input  logic             exMemRD,
   input  logic             exDoJump,
   input  logic             exBrTaken,
   input  logic             memReq,
   input  logic             memReady,
   output logic             pcWrEn,
   output logic             pcSel,
   output logic             ifidWrEn,
   output logic             ifidFlush,
   output logic             idexFlush,
   output logic             exmemWrEn,
   output logic             memwbBubble,
   output logic             memErr,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   localparam int              TO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   pipe_state_t     state_q, state_d;
   logic [TO_W-1:0] tmo_q, tmo_d;
   logic            err_q, err_d;
   logic            mem_wait, redirect, load_use;
   logic            stall_inc, flush_inc;

   assign mem_wait = memReq & ~memReady;
   assign redirect = exBrTaken | exDoJump;
   assign load_use = exMemRD && (exRd != REG_X0) &&
                     (src_matches(idUsesRs1, idRs1, exRd) ||
                      src_matches(idUsesRs2, idRs2, exRd));

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      pcWrEn      = 1'b1;
      pcSel       = 1'b0;
      ifidWrEn    = 1'b1;
      ifidFlush   = 1'b0;
      idexFlush   = 1'b0;
      exmemWrEn   = 1'b1;
      memwbBubble = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      if (!rstN) begin
         pcWrEn      = 1'b0;
         ifidWrEn    = 1'b0;
         exmemWrEn   = 1'b0;
         ifidFlush   = 1'b1;
         idexFlush   = 1'b1;
         memwbBubble = 1'b1;
      end else begin
         unique case (state_q)
            ERROR: begin
               pcWrEn      = 1'b0;
               ifidWrEn    = 1'b0;
               exmemWrEn   = 1'b0;
               memwbBubble = 1'b1;
            end
            RUN, MEMWAIT: begin
               if (mem_wait) begin
                  pcWrEn      = 1'b0;
                  ifidWrEn    = 1'b0;
                  exmemWrEn   = 1'b0;
                  memwbBubble = 1'b1;
                  stall_inc   = 1'b1;
                  if (state_q == RUN) begin
                     state_d = MEMWAIT;
                     tmo_d   = '0;
                  end else if (tmo_q == TO_LAST) begin
                     state_d = ERROR;
                     err_d   = 1'b1;
                  end else begin
                     tmo_d = tmo_q + TO_W'(1);
                  end
               end else begin
                  // Held redirect/load-use is re-evaluated here once memory completes.
                  state_d = RUN;
                  tmo_d   = '0;
                  if (redirect) begin
                     pcSel     = 1'b1;
                     ifidFlush = 1'b1;
                     idexFlush = 1'b1;
                     flush_inc = 1'b1;
                  end else if (load_use) begin
                     pcWrEn    = 1'b0;
                     ifidWrEn  = 1'b0;
                     idexFlush = 1'b1;
                     stall_inc = 1'b1;
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= RUN;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign memErr = err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk  (clk),
      .rstN (rstN),
      .inc  (stall_inc),
      .cnt  (stallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk  (clk),
      .rstN (rstN),
      .inc  (flush_inc),
      .cnt  (flushCount)
   );

endmodule
